// File: rtl/ncl_op_sequencer.sv
// ncl_op_sequencer: drives one opcode at a time into the dual-rail NCL
// opcode decoder with a four-phase DATA/NULL protocol. The decoded result
// comes back as a single-rail valid/ready transaction. Owns timeout and
// stuck-NULL fault handling for the asynchronous decode island.
module ncl_op_sequencer #(
  parameter int TIMEOUT = 63,
  parameter int CNT_W   = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [3:0] op,
  output logic [3:0] i_t,
  output logic [3:0] i_f,
  input  logic [2:0] c_t,
  input  logic [2:0] c_f,
  output logic       ctl_valid,
  input  logic       ctl_ready,
  output logic [2:0] ctl,
  output logic       ctl_bypass,
  output logic       ctl_err,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_NULL,
    S_OUT,
    S_FAULT
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_ct_s1, r_ct_s2, r_cf_s1, r_cf_s2;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_it, r_if, w_it_nxt, w_if_nxt;
  logic [2:0]       r_ctl, w_ctl_nxt;
  logic             r_byp, w_byp_nxt;
  logic             r_err, w_err_nxt;

  logic w_done_data, w_done_null, w_orphan, w_tmo;

  // Completion detection only ever looks at the synchronized rails.
  assign w_done_data = &(r_ct_s2 ^ r_cf_s2);
  assign w_done_null = ~|{r_ct_s2, r_cf_s2};
  assign w_orphan    = |(r_ct_s2 & r_cf_s2);
  assign w_tmo       = (r_cnt == CNT_W'(TIMEOUT));

  // Two-flop synchronizer on all six asynchronous decoder rails.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ct_s1 <= '0;
      r_ct_s2 <= '0;
      r_cf_s1 <= '0;
      r_cf_s2 <= '0;
    end else begin
      r_ct_s1 <= c_t;
      r_ct_s2 <= r_ct_s1;
      r_cf_s1 <= c_f;
      r_cf_s2 <= r_cf_s1;
    end
  end

  // State, rail, counter and result registers; reset forces rails to NULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_it    <= '0;
      r_if    <= '0;
      r_ctl   <= '0;
      r_byp   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_it    <= w_it_nxt;
      r_if    <= w_if_nxt;
      r_ctl   <= w_ctl_nxt;
      r_byp   <= w_byp_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state logic: orphan beats done_data, done_data beats timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_it_nxt    = r_it;
    w_if_nxt    = r_if;
    w_ctl_nxt   = r_ctl;
    w_byp_nxt   = r_byp;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE: begin
        if (op_valid) begin
          if (op[3] == op[2]) begin
            // Not a decoder opcode: answer directly, rails stay NULL.
            w_ctl_nxt   = '0;
            w_byp_nxt   = 1'b1;
            w_err_nxt   = 1'b0;
            w_state_nxt = S_OUT;
          end else begin
            w_it_nxt    = op;
            w_if_nxt    = ~op;
            w_cnt_nxt   = '0;
            w_state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_orphan || (!w_done_data && w_tmo)) begin
          w_ctl_nxt   = '0;
          w_byp_nxt   = 1'b0;
          w_err_nxt   = 1'b1;
          w_it_nxt    = '0;
          w_if_nxt    = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_NULL;
        end else if (w_done_data) begin
          w_ctl_nxt   = r_ct_s2;
          w_byp_nxt   = 1'b0;
          w_err_nxt   = 1'b0;
          w_it_nxt    = '0;
          w_if_nxt    = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_NULL;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_NULL: begin
        if (w_done_null) begin
          w_state_nxt = S_OUT;
        end else if (w_tmo) begin
          w_state_nxt = S_FAULT;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_OUT: begin
        if (ctl_ready) w_state_nxt = S_IDLE;
      end
      S_FAULT: begin
        w_state_nxt = S_FAULT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign op_ready   = (r_state == S_IDLE);
  assign ctl_valid  = (r_state == S_OUT);
  assign fault      = (r_state == S_FAULT);
  assign i_t        = r_it;
  assign i_f        = r_if;
  assign ctl        = r_ctl;
  assign ctl_bypass = r_byp;
  assign ctl_err    = r_err;

endmodule

// File: tb/tb_ncl_op_sequencer.sv
// Bench for ncl_op_sequencer: behavioural NCL decoder model with fault
// modes, scoreboard of expected results, latency and protocol checks.
module tb_ncl_op_sequencer;

  logic       clk, rst_n;
  logic       op_valid, op_ready;
  logic [3:0] op, i_t, i_f;
  logic [2:0] c_t, c_f, ctl;
  logic       ctl_valid, ctl_ready, ctl_bypass, ctl_err, fault;

  typedef struct packed {
    logic [2:0] ctl;
    logic       byp;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   mode   = 0;  // 0: normal decoder, 1: silent, 2: C1O_t stuck high

  ncl_op_sequencer #(.TIMEOUT(63), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready), .op(op),
    .i_t(i_t), .i_f(i_f), .c_t(c_t), .c_f(c_f),
    .ctl_valid(ctl_valid), .ctl_ready(ctl_ready), .ctl(ctl),
    .ctl_bypass(ctl_bypass), .ctl_err(ctl_err), .fault(fault)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Reference decode {C1A1, C1A0, C1O} for the decoder model.
  function automatic logic [2:0] dec(input logic [3:0] v);
    return {v[2] & v[1], v[0], v[2]};
  endfunction

  // Decoder model: answers as soon as every input bit is DATA.
  always_comb begin
    c_t = '0;
    c_f = '0;
    if ((i_t | i_f) == 4'hF && mode != 1) begin
      c_t = dec(i_t);
      c_f = ~dec(i_t);
    end
    if (mode == 2) c_t[0] = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: a handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && ctl_valid && ctl_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ctl", ctl, e.ctl);
        chk("ctl_bypass", ctl_bypass, e.byp);
        chk("ctl_err", ctl_err, e.err);
      end
    end
  end

  // Offer v from a negedge; returns at #1 after the accept edge (cycle 1).
  task automatic accept(input logic [3:0] v);
    int   n;
    exp_t e;
    n = 0;
    op = v;
    op_valid = 1;
    while (!op_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", n < 100, 1);
    if (v[3] == v[2])   e = '{ctl: 3'b000, byp: 1'b1, err: 1'b0};
    else if (mode == 1) e = '{ctl: 3'b000, byp: 1'b0, err: 1'b1};
    else                e = '{ctl: dec(v), byp: 1'b0, err: 1'b0};
    if (mode != 2) q.push_back(e);
    @(posedge clk);
    #1 op_valid = 0;
  endtask

  // Advance until ctl_valid; lat holds the cycle number it appeared in.
  task automatic wait_valid(input int start, output int lat);
    lat = start;
    while (!ctl_valid && lat < 300) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("valid_timeout", lat < 300, 1);
  endtask

  initial begin
    int lat, n;
    logic [3:0] tv [3];
    rst_n = 0; op_valid = 0; op = '0; ctl_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_op_ready", op_ready, 1);
    chk("rst_i_t", i_t, 0);
    chk("rst_i_f", i_f, 0);
    chk("rst_ctl_valid", ctl_valid, 0);
    chk("rst_fault", fault, 0);
    @(negedge clk) rst_n = 1;
    @(negedge clk);

    // Decoded op 1001 with exact phase timing.
    accept(4'b1001);
    chk("data_i_t", i_t, 4'b1001);
    chk("data_i_f", i_f, 4'b0110);
    repeat (2) begin @(posedge clk); #1; end
    chk("c3_still_data", i_t, 4'b1001);
    @(posedge clk); #1;
    chk("c4_null_i_t", i_t, 0);
    chk("c4_null_i_f", i_f, 0);
    wait_valid(4, lat);
    chk("lat_decoded", lat, 7);
    @(posedge clk); #1;
    chk("op_ready_after_hs", op_ready, 1);
    @(negedge clk);

    // Backpressure: 0111 held for 5 cycles.
    ctl_ready = 0;
    accept(4'b0111);
    wait_valid(1, lat);
    for (int i = 0; i < 5; i++) begin
      chk("bp_ctl", ctl, 3'b111);
      chk("bp_valid", ctl_valid, 1);
      chk("bp_op_ready", op_ready, 0);
      @(posedge clk); #1;
    end
    ctl_ready = 1;
    chk("bp_op_ready_pre", op_ready, 0);
    @(posedge clk); #1;
    chk("bp_op_ready_post", op_ready, 1);
    @(negedge clk);

    // Bypass opcodes: result in cycle 1, rails never leave NULL.
    tv[0] = 4'b1100; tv[1] = 4'b0010;
    for (int i = 0; i < 2; i++) begin
      accept(tv[i]);
      chk("byp_i_t", i_t, 0);
      chk("byp_i_f", i_f, 0);
      chk("byp_lat_valid", ctl_valid, 1);
      @(negedge clk); @(negedge clk);
    end

    // More decoded ops, back-to-back.
    tv[0] = 4'b1010; tv[1] = 4'b0100; tv[2] = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      accept(tv[i]);
      wait_valid(1, lat);
      chk("lat_loop", lat, 7);
      @(negedge clk); @(negedge clk);
    end

    // Reset mid-DATA: rails clear asynchronously, op is discarded.
    accept(4'b1001);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk("rst_async_i_t", i_t, 0);
    chk("rst_async_i_f", i_f, 0);
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ctl_valid) n++;
    end
    chk("rst_no_valid", n, 0);
    accept(4'b0111);
    wait_valid(1, lat);
    chk("lat_after_rst", lat, 7);
    @(negedge clk); @(negedge clk);

    // DATA timeout with a silent decoder.
    mode = 1;
    accept(4'b1001);
    n = 1;
    while (i_t != 0 && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    chk("to_null_window", (n >= 64 && n <= 65), 1);
    wait_valid(n, lat);
    @(negedge clk); @(negedge clk);
    mode = 0;

    // Stuck NULL: C1O_t held high drives the island into FAULT.
    mode = 2;
    accept(4'b1001);
    n = 0;
    while (!fault && n < 400) begin
      @(posedge clk);
      #1 n++;
    end
    chk("fault_set", fault, 1);
    chk("fault_op_ready", op_ready, 0);
    chk("fault_valid", ctl_valid, 0);
    chk("fault_rails", i_t | i_f, 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("fault_sticky", fault, 1);
    rst_n = 0;
    #1;
    chk("fault_clr", fault, 0);
    chk("fault_clr_ready", op_ready, 1);
    mode = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(negedge clk);
    accept(4'b1010);
    wait_valid(1, lat);
    chk("lat_after_fault", lat, 7);
    repeat (3) @(negedge clk);

    chk("sb_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ncl_op_sequencer.md
# ncl_op_sequencer

Clocked sequencer that drives one 4-bit opcode field at a time into the dual-rail NCL opcode decoder. It uses a full four-phase DATA/NULL protocol on rails I7..I4 and waits for completion on the three decoder outputs (C1A1, C1A0, C1O). It returns the decoded control bits as a single-rail valid/ready transaction. It sits between the synchronous fetch stage and the asynchronous decode island, and owns the timeout and fault handling for that island.

## Interface
- TIMEOUT, 63: max cycles the sequencer waits in DATA or NULL before declaring a timeout.
- CNT_W, 6: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  opcode offered.
- op_ready  out  1  sequencer accepts an opcode.
- op  in  4  opcode: [3]=I7, [2]=I6, [1]=I5, [0]=I4.
- i_t  out  4  true rails to the decoder, same bit order as op.
- i_f  out  4  false rails to the decoder, same bit order as op.
- c_t  in  3  decoder true rails, asynchronous: [2]=C1A1, [1]=C1A0, [0]=C1O.
- c_f  in  3  decoder false rails, asynchronous, same order as c_t.
- ctl_valid  out  1  decoded result available.
- ctl_ready  in  1  consumer accepts the result.
- ctl  out  3  decoded control {C1A1, C1A0, C1O}.
- ctl_bypass  out  1  opcode not handled by the decoder (op[3]==op[2]); ctl is 0.
- ctl_err  out  1  result invalid (timeout or orphan detected); ctl is 0.
- fault  out  1  decode island failed to return to NULL; sticky until reset.

## Operation
- All 6 decoder rails pass through a 2-flop synchronizer. All decisions use the synchronized values.
- On the synchronized rails:
  - done_data: every output has exactly one rail high.
  - done_null: all 6 rails are low.
  - orphan: any output has both rails high.
- i_t and i_f are registered. Dual-rail coding per bit: DATA drives i_t=op and i_f=~op; NULL drives both to 0.
- States: IDLE, DATA, NULL, OUT, FAULT. op_ready = (state==IDLE).
- IDLE, when op_valid is high:
  - Capture op.
  - If op[3]==op[2]: go to OUT with ctl=0, ctl_bypass=1, ctl_err=0. Rails stay NULL.
  - Otherwise: drive DATA rails, clear the counter, go to DATA.
- DATA:
  - On done_data: capture ctl=c_t (synced), ctl_bypass=0, ctl_err=0. Drive NULL, clear the counter, go to NULL.
  - On orphan, or counter==TIMEOUT: set ctl=0 and ctl_err=1. Drive NULL, clear the counter, go to NULL.
  - Orphan takes priority over done_data in the same cycle.
- NULL:
  - On done_null: go to OUT.
  - If counter==TIMEOUT: go to FAULT.
- OUT: ctl_valid=1. ctl, ctl_bypass and ctl_err are held stable. When ctl_ready is high, go to IDLE.
- FAULT: fault=1, op_ready=0, ctl_valid=0, rails NULL. The only exit is reset.
- Counter: increments every cycle spent in DATA or NULL and saturates at TIMEOUT.
- Reset (asynchronous, at any time, including mid-handshake):
  - state goes to IDLE; i_t and i_f go to 0 (NULL) immediately.
  - ctl_valid, ctl, ctl_bypass, ctl_err, fault, the counter and the synchronizers all go to 0.
  - op_ready=1 once in IDLE.
  - Any in-flight opcode is discarded; no result is produced for it.

## Timing
- Accept edge is E0. The DATA rails are visible in cycle 1.
- With a decoder faster than one cycle, done_data is seen in cycle 3. NULL rails drive from cycle 4.
- done_null is seen in cycle 6. ctl_valid rises in cycle 7, giving a minimum latency of 7 cycles.
- A bypass opcode gives ctl_valid in cycle 1.
- After the ctl_ready handshake, op_ready is high in the following cycle. Peak throughput is one decoded op per 8 cycles.
- Rails never change from DATA to DATA. A NULL phase always separates two DATA phases.
- A timeout is declared at the earliest TIMEOUT cycles after entering DATA or NULL.

## Test plan
- Decoded op: op=4'b1001 accepted. Required response: i_t=1001 and i_f=0110 in cycle 1; rails go NULL after done_data; ctl_valid in cycle 7 with ctl=3'b010 and ctl_bypass=ctl_err=0.
- Decoded op with consumer backpressure: op=4'b0111, ctl_ready held low for 5 cycles. Required response: ctl=3'b111 held stable with ctl_valid high; op_ready stays low until the cycle after ctl_ready rises.
- Bypass: op=4'b1100 and then op=4'b0010. Required response: ctl_valid in cycle 1 with ctl_bypass=1 and ctl=0; i_t and i_f stay 0 throughout.
- DATA timeout: decoder model never asserts outputs, TIMEOUT=63. Required response: NULL rails driven at most 64 cycles after entering DATA; the result is delivered with ctl_err=1 and ctl=0.
- Stuck NULL: decoder model holds C1O_t high forever. Required response: state goes to FAULT with fault=1 and op_ready=0; rst_n low clears fault and returns op_ready=1.
- Reset mid-DATA: assert rst_n low in cycle 2 of an op. Required response: i_t and i_f go to 0 without waiting for a clock edge; no ctl_valid follows; the next op completes normally.
